// File: rtl/ir_pkg.sv
// Shared definitions for the instruction-register assembler: default widths,
// the CPU opcode map, the default short-opcode mask and the FSM state type.
package ir_pkg;

    localparam int BUS_W_DEF  = 8;
    localparam int BEATS_DEF  = 2;
    localparam int OP_W_DEF   = 3;
    localparam int ADDR_W_DEF = 13;

    localparam logic [OP_W_DEF-1:0] OP_HLT = 3'd0;
    localparam logic [OP_W_DEF-1:0] OP_SKZ = 3'd1;
    localparam logic [OP_W_DEF-1:0] OP_ADD = 3'd2;
    localparam logic [OP_W_DEF-1:0] OP_AND = 3'd3;
    localparam logic [OP_W_DEF-1:0] OP_XOR = 3'd4;
    localparam logic [OP_W_DEF-1:0] OP_LDA = 3'd5;
    localparam logic [OP_W_DEF-1:0] OP_STO = 3'd6;
    localparam logic [OP_W_DEF-1:0] OP_JMP = 3'd7;

    // Every opcode of the base ISA carries a full address, so none is short.
    localparam logic [2**OP_W_DEF-1:0] SHORT_MASK_DEF = '0;

    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } ir_state_e;

endpackage

// File: rtl/ir_assembler_if.sv
// Beat-in / instruction-out channel between the data bus, the instruction
// register and the controller. The assembler takes the slave side.
interface ir_assembler_if
    import ir_pkg::*;
#(
    parameter int BUS_W  = BUS_W_DEF,
    parameter int BEATS  = BEATS_DEF,
    parameter int OP_W   = OP_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    localparam int IDX_W = $clog2(BEATS);

    logic              load_ir;
    logic [BUS_W-1:0]  data;
    logic              flush;
    logic              ir_ack;
    logic              load_ready;
    logic              ir_valid;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [IDX_W-1:0]  beat_idx;

    modport master (
        output load_ir, data, flush, ir_ack,
        input  load_ready, ir_valid, opcode, ir_addr, beat_idx
    );

    modport slave (
        input  load_ir, data, flush, ir_ack,
        output load_ready, ir_valid, opcode, ir_addr, beat_idx
    );

endinterface

// File: rtl/ir_beat_shifter.sv
// Assembly register: writes one BUS_W slice big-endian at a beat index and
// exposes the would-be word so the caller can capture it on the same edge.
module ir_beat_shifter #(
    parameter int BUS_W = 8,
    parameter int BEATS = 2,
    parameter int IDX_W = $clog2(BEATS)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   wr_en,
    input  logic                   zero_fill,
    input  logic [IDX_W-1:0]       idx,
    input  logic [BUS_W-1:0]       slice,
    output logic [BUS_W*BEATS-1:0] word_next
);

    localparam int WORD_W = BUS_W * BEATS;

    logic [WORD_W-1:0] word;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        word_next = zero_fill ? '0 : word;
        for (int k = 0; k < BEATS; k++) begin
            if (idx == IDX_W'(k)) begin
                word_next[BUS_W*(BEATS-1-k) +: BUS_W] = slice;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            word <= '0;
        end else if (wr_en) begin
            word <= word_next;
        end
    end

endmodule

// File: rtl/ir_assembler.sv
// Instruction register that assembles one opcode+address word from BEATS
// narrow bus beats, with short opcodes, flush and valid/ack back-pressure.
module ir_assembler
    import ir_pkg::*;
#(
    parameter int                  BUS_W      = BUS_W_DEF,
    parameter int                  BEATS      = BEATS_DEF,
    parameter int                  OP_W       = OP_W_DEF,
    parameter int                  ADDR_W     = ADDR_W_DEF,
    parameter logic [2**OP_W-1:0]  SHORT_MASK = (2**OP_W)'(SHORT_MASK_DEF)
) (
    input logic          clk,
    input logic          rst_n,
    ir_assembler_if.slave bus
);

    localparam int WORD_W = BUS_W * BEATS;
    localparam int IDX_W  = $clog2(BEATS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BEATS - 1);

    ir_state_e         state, state_next;
    logic [IDX_W-1:0]  beat_idx, idx_next;

    logic              is_short;
    logic              final_beat;
    logic              load_ready;
    logic              accept;
    logic              complete;
    logic              zero_fill;

    logic              ir_valid;
    logic [OP_W-1:0]   opcode;
    logic [ADDR_W-1:0] ir_addr;
    logic [WORD_W-1:0] word_next;
    logic [OP_W-1:0]   data_op;

    assign data_op = bus.data[BUS_W-1 -: OP_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat_idx <= '0;
        end else begin
            state    <= state_next;
            beat_idx <= idx_next;
        end
    end

    always_comb begin
        state_next = state;
        idx_next   = beat_idx;
        if (bus.flush) begin
            state_next = IDLE;
            idx_next   = '0;
        end else if (accept) begin
            unique case (state)
                IDLE: begin
                    if (!is_short) begin
                        state_next = COLLECT;
                        idx_next   = IDX_W'(1);
                    end
                end
                COLLECT: begin
                    if (beat_idx == LAST_IDX) begin
                        state_next = IDLE;
                        idx_next   = '0;
                    end else begin
                        idx_next = beat_idx + IDX_W'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                    idx_next   = '0;
                end
            endcase
        end
    end

    // Only the beat that would complete an instruction is stalled; earlier
    // beats keep collecting while the previous instruction waits for ack.
    always_comb begin
        is_short   = SHORT_MASK[data_op];
        final_beat = (state == COLLECT) ? (beat_idx == LAST_IDX) : is_short;
        load_ready = !(ir_valid && !bus.ir_ack && final_beat);
        accept     = bus.load_ir && load_ready && !bus.flush;
        complete   = accept && final_beat;
        zero_fill  = (state == IDLE) && is_short;
    end

    ir_beat_shifter #(
        .BUS_W (BUS_W),
        .BEATS (BEATS),
        .IDX_W (IDX_W)
    ) u_shifter (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_en     (accept),
        .zero_fill (zero_fill),
        .idx       (beat_idx),
        .slice     (bus.data),
        .word_next (word_next)
    );

    // Outputs load from the post-write word so a completed instruction is
    // visible on the very edge that samples its last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ir_valid <= 1'b0;
            opcode   <= '0;
            ir_addr  <= '0;
        end else if (bus.flush) begin
            ir_valid <= 1'b0;
        end else if (complete) begin
            ir_valid <= 1'b1;
            opcode   <= word_next[WORD_W-1 -: OP_W];
            ir_addr  <= word_next[ADDR_W-1:0];
        end else if (bus.ir_ack) begin
            ir_valid <= 1'b0;
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.ir_valid   = ir_valid;
    assign bus.opcode     = opcode;
    assign bus.ir_addr    = ir_addr;
    assign bus.beat_idx   = beat_idx;

endmodule

// File: tb/tb_ir_assembler.sv
// Directed bench for ir_assembler: default 8-bit build, a build with opcode 7
// marked short, and a 16-bit 3-beat build, all checked against fixed vectors.
module tb_ir_assembler;
    import ir_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       load_ir;
    logic       flush;
    logic       ir_ack;
    logic [7:0] data;

    int n_cmp;
    int n_bad;

    ir_assembler_if #(.BUS_W(8),  .BEATS(2), .OP_W(3), .ADDR_W(13)) if_d ();
    ir_assembler_if #(.BUS_W(8),  .BEATS(2), .OP_W(3), .ADDR_W(13)) if_s ();
    ir_assembler_if #(.BUS_W(16), .BEATS(3), .OP_W(5), .ADDR_W(43)) if_w ();

    assign if_d.load_ir = load_ir;
    assign if_d.data    = data;
    assign if_d.flush   = flush;
    assign if_d.ir_ack  = ir_ack;
    assign if_s.load_ir = load_ir;
    assign if_s.data    = data;
    assign if_s.flush   = flush;
    assign if_s.ir_ack  = ir_ack;

    ir_assembler dut_d (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_d.slave)
    );

    ir_assembler #(
        .BUS_W      (8),
        .BEATS      (2),
        .OP_W       (3),
        .ADDR_W     (13),
        .SHORT_MASK (8'h80)
    ) dut_s (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s.slave)
    );

    ir_assembler #(
        .BUS_W  (16),
        .BEATS  (3),
        .OP_W   (5),
        .ADDR_W (43)
    ) dut_w (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_w.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [7:0] d);
        load_ir = 1'b1;
        data    = d;
        tick();
        load_ir = 1'b0;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        load_ir = 1'b0;
        flush   = 1'b0;
        ir_ack  = 1'b0;
        data    = '0;
        if_w.load_ir = 1'b0;
        if_w.data    = '0;
        if_w.flush   = 1'b0;
        if_w.ir_ack  = 1'b0;

        #3;
        check("rst_opcode",   64'(if_d.opcode),   64'h0);
        check("rst_addr",     64'(if_d.ir_addr),  64'h0);
        check("rst_valid",    64'(if_d.ir_valid), 64'h0);
        check("rst_beat_idx", 64'(if_d.beat_idx), 64'h0);
        #9;
        rst_n = 1'b1;
        tick();

        // Reset in the middle of an instruction drops the partial beat.
        beat(8'hA5);
        check("mid_beat_idx", 64'(if_d.beat_idx), 64'h1);
        rst_n = 1'b0;
        #2;
        check("mid_rst_opcode", 64'(if_d.opcode),   64'h0);
        check("mid_rst_addr",   64'(if_d.ir_addr),  64'h0);
        check("mid_rst_valid",  64'(if_d.ir_valid), 64'h0);
        check("mid_rst_idx",    64'(if_d.beat_idx), 64'h0);
        rst_n = 1'b1;
        tick();
        beat(8'h3C);
        check("after_rst_idx",   64'(if_d.beat_idx), 64'h1);
        check("after_rst_valid", 64'(if_d.ir_valid), 64'h0);
        beat(8'h00);
        check("after_rst_done",  64'(if_d.ir_valid), 64'h1);
        check("after_rst_op",    64'(if_d.opcode),   64'(OP_SKZ));
        check("after_rst_addr",  64'(if_d.ir_addr),  64'h1C00);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        check("ack_clears", 64'(if_d.ir_valid), 64'h0);

        // Full instruction with an idle gap between beats.
        beat(8'hB7);
        tick();
        tick();
        check("gap_idx_held", 64'(if_d.beat_idx), 64'h1);
        check("gap_no_valid", 64'(if_d.ir_valid), 64'h0);
        beat(8'h42);
        check("full_valid",   64'(if_d.ir_valid), 64'h1);
        check("full_opcode",  64'(if_d.opcode),   64'(OP_LDA));
        check("full_addr",    64'(if_d.ir_addr),  64'h1742);
        check("full_addr_s",  64'(if_s.ir_addr),  64'h1742);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        check("full_ack", 64'(if_d.ir_valid), 64'h0);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;
        check("idle_ack_valid", 64'(if_d.ir_valid), 64'h0);
        check("idle_ack_idx",   64'(if_d.beat_idx), 64'h0);

        // Short opcode: one beat completes on dut_s, dut_d keeps collecting.
        beat(8'hE9);
        check("short_valid",   64'(if_s.ir_valid), 64'h1);
        check("short_opcode",  64'(if_s.opcode),   64'(OP_JMP));
        check("short_addr",    64'(if_s.ir_addr),  64'h0900);
        check("short_idx",     64'(if_s.beat_idx), 64'h0);
        check("long_idx",      64'(if_d.beat_idx), 64'h1);
        check("long_no_valid", 64'(if_d.ir_valid), 64'h0);
        load_ir = 1'b1;
        data    = 8'hE9;
        flush   = 1'b1;
        #1;
        check("short_stall_ready", 64'(if_s.load_ready), 64'h0);
        check("long_final_ready",  64'(if_d.load_ready), 64'h1);
        tick();
        load_ir = 1'b0;
        flush   = 1'b0;
        check("short_flush_valid", 64'(if_s.ir_valid), 64'h0);
        check("short_flush_op",    64'(if_s.opcode),   64'(OP_JMP));
        check("short_flush_addr",  64'(if_s.ir_addr),  64'h0900);
        check("long_flush_idx",    64'(if_d.beat_idx), 64'h0);

        // Back-pressure on the final beat while an instruction is pending.
        beat(8'hB7);
        beat(8'h42);
        load_ir = 1'b1;
        data    = 8'h21;
        #1;
        check("bp_first_ready", 64'(if_d.load_ready), 64'h1);
        tick();
        check("bp_first_idx",   64'(if_d.beat_idx), 64'h1);
        check("bp_old_valid",   64'(if_d.ir_valid), 64'h1);
        data = 8'h10;
        #1;
        check("bp_final_ready", 64'(if_d.load_ready), 64'h0);
        tick();
        check("bp_held_idx",    64'(if_d.beat_idx), 64'h1);
        check("bp_held_addr",   64'(if_d.ir_addr),  64'h1742);
        check("bp_held_op",     64'(if_d.opcode),   64'(OP_LDA));
        ir_ack = 1'b1;
        #1;
        check("bp_ack_ready",   64'(if_d.load_ready), 64'h1);
        tick();
        load_ir = 1'b0;
        ir_ack  = 1'b0;
        check("bp_new_valid",   64'(if_d.ir_valid), 64'h1);
        check("bp_new_op",      64'(if_d.opcode),   64'(OP_SKZ));
        check("bp_new_addr",    64'(if_d.ir_addr),  64'h0110);
        check("bp_new_idx",     64'(if_d.beat_idx), 64'h0);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;

        // Flush beats a concurrent load.
        beat(8'h55);
        check("fl_idx_before", 64'(if_d.beat_idx), 64'h1);
        load_ir = 1'b1;
        data    = 8'h66;
        flush   = 1'b1;
        tick();
        load_ir = 1'b0;
        flush   = 1'b0;
        check("fl_idx",   64'(if_d.beat_idx), 64'h0);
        check("fl_valid", 64'(if_d.ir_valid), 64'h0);
        check("fl_op",    64'(if_d.opcode),   64'(OP_SKZ));
        check("fl_addr",  64'(if_d.ir_addr),  64'h0110);
        beat(8'h66);
        beat(8'h01);
        check("post_fl_op",   64'(if_d.opcode),  64'(OP_AND));
        check("post_fl_addr", 64'(if_d.ir_addr), 64'h0601);
        ir_ack = 1'b1;
        tick();
        ir_ack = 1'b0;

        // Wide build: 16-bit bus, three beats, 5-bit opcode.
        if_w.load_ir = 1'b1;
        if_w.data    = 16'hF800;
        tick();
        check("w_idx1", 64'(if_w.beat_idx), 64'h1);
        if_w.data = 16'h1234;
        tick();
        check("w_idx2",     64'(if_w.beat_idx), 64'h2);
        check("w_no_valid", 64'(if_w.ir_valid), 64'h0);
        if_w.data = 16'h5678;
        tick();
        if_w.load_ir = 1'b0;
        check("w_valid",  64'(if_w.ir_valid), 64'h1);
        check("w_opcode", 64'(if_w.opcode),   64'h1F);
        check("w_addr",   64'(if_w.ir_addr),  64'h000_1234_5678);
        check("w_idx0",   64'(if_w.beat_idx), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
